hilo_unit: RTL

Sequencing and holding stage that sits directly upstream and downstream of the 32-bit iterative divider in the multicycle datapath. It accepts a divide request from the main control unit and pre-checks for a zero divisor. It then launches the divider with a one-cycle pulse, waits for completion under a watchdog, and captures the result into the architectural HI/LO registers. It also services mthi/mtlo writes and supplies busy/done/exception handshakes to control.

---
 rtl/hilo_pkg.sv | 13 +
 rtl/hilo_watchdog.sv | 29 ++
 rtl/hilo_unit.sv | 101 ++++++++++
 3 files changed

// File: rtl/hilo_pkg.sv
// Shared types and constants for the HI/LO divide sequencing stage.
package hilo_pkg;

    localparam int DATA_W          = 32;
    localparam int DEFAULT_TIMEOUT = 40;

    typedef enum logic [1:0] {
        IDLE,
        LAUNCH,
        WAIT
    } hilo_state_t;

endpackage

// File: rtl/hilo_watchdog.sv
// Eight-bit cycle counter that flags expiry once it has counted to TIMEOUT-1.
module hilo_watchdog
    import hilo_pkg::*;
#(
    parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    logic [7:0] count;

    // The count parks at the expiry value until the next clear.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && !expire) begin
            count <= count + 8'd1;
        end
    end

    assign expire = (count == 8'(TIMEOUT - 1));

endmodule

// File: rtl/hilo_unit.sv
// Launches the iterative divider, watches for completion and holds the HI/LO result.
module hilo_unit
    import hilo_pkg::*;
#(
    parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [DATA_W-1:0] a_in,
    input  logic [DATA_W-1:0] b_in,
    input  logic              mthi,
    input  logic              mtlo,
    input  logic [DATA_W-1:0] wr_data,
    output logic              div_start,
    output logic [DATA_W-1:0] div_a,
    output logic [DATA_W-1:0] div_b,
    input  logic [DATA_W-1:0] div_high,
    input  logic [DATA_W-1:0] div_low,
    input  logic              div_done,
    output logic [DATA_W-1:0] hi,
    output logic [DATA_W-1:0] lo,
    output logic              busy,
    output logic              done,
    output logic              div_zero,
    output logic              timeout_err
);

    hilo_state_t state;
    logic        wd_expire;

    hilo_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clk    (clk),
        .reset  (reset),
        .clear  (state == LAUNCH),
        .enable (state == WAIT),
        .expire (wd_expire)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            div_start   <= 1'b0;
            div_a       <= '0;
            div_b       <= '0;
            hi          <= '0;
            lo          <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            div_zero    <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            div_start   <= 1'b0;
            done        <= 1'b0;
            div_zero    <= 1'b0;
            timeout_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (mthi) hi <= wr_data;
                    if (mtlo) lo <= wr_data;
                    // A zero divisor is trapped here so the divider never sees it.
                    if (start) begin
                        if (b_in == '0) begin
                            div_zero <= 1'b1;
                        end else begin
                            div_a     <= a_in;
                            div_b     <= b_in;
                            div_start <= 1'b1;
                            busy      <= 1'b1;
                            state     <= LAUNCH;
                        end
                    end
                end
                LAUNCH: begin
                    state <= WAIT;
                end
                WAIT: begin
                    // Completion is checked first so it beats a coincident expiry.
                    if (div_done) begin
                        hi    <= div_high;
                        lo    <= div_low;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else if (wd_expire) begin
                        timeout_err <= 1'b1;
                        busy        <= 1'b0;
                        state       <= IDLE;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
